// File: rtl/multi_edge_detector.sv
// Multi-channel gate edge detector: per-channel synchroniser, run-length filter,
// registered rising/falling pulses, mask-qualified events and saturating counters.
module multi_edge_detector #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned FILTER_LEN  = 1,
  parameter int unsigned CNT_W       = 16,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         gate,
  input  logic [N_CH-1:0]         ch_enable,
  input  logic [N_CH-1:0]         rise_mask,
  input  logic [N_CH-1:0]         fall_mask,
  input  logic [N_CH-1:0]         cnt_clear,
  output logic [N_CH-1:0]         level,
  output logic [N_CH-1:0]         rising_edge,
  output logic [N_CH-1:0]         falling_edge,
  // 'event' is a reserved word in SystemVerilog
  output logic [N_CH-1:0]         event_out,
  output logic                    any_event,
  output logic [N_CH*CNT_W-1:0]   event_count,
  output logic [N_CH-1:0]         count_sat
);

  localparam int unsigned         FCNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

  logic [N_CH-1:0]   sync_q [SYNC_STAGES];
  logic [N_CH-1:0]   sync_d [SYNC_STAGES];
  logic [N_CH-1:0]   level_q, level_d;
  logic [FCNT_W-1:0] fcnt_q [N_CH];
  logic [FCNT_W-1:0] fcnt_d [N_CH];
  logic [N_CH-1:0]   rise_q, rise_d;
  logic [N_CH-1:0]   fall_q, fall_d;
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [N_CH-1:0]   sat_q, sat_d;
  logic [N_CH-1:0]   ev;

  always_comb begin
    sync_d[0] = gate;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Level toggles only after FILTER_LEN consecutive mismatching samples.
  always_comb begin
    level_d = level_q;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      fcnt_d[ch] = '0;
      if (sync_q[SYNC_STAGES-1][ch] != level_q[ch]) begin
        if (fcnt_q[ch] == FCNT_LAST) begin
          level_d[ch] = ~level_q[ch];
        end else begin
          fcnt_d[ch] = fcnt_q[ch] + FCNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise_d = level_d & ~level_q & ch_enable;
    fall_d = ~level_d & level_q & ch_enable;
    ev     = (rise_q & rise_mask) | (fall_q & fall_mask);
  end

  always_comb begin
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (cnt_clear[ch]) begin
        cnt_d[ch] = '0;
      end else if (ev[ch] && (cnt_q[ch] != '1)) begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
      sat_d[ch] = (cnt_d[ch] == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {N_CH{INIT_LEVEL}};
      end
      level_q <= {N_CH{INIT_LEVEL}};
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        fcnt_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
      rise_q <= '0;
      fall_q <= '0;
      sat_q  <= '0;
    end else begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      level_q <= level_d;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        fcnt_q[ch] <= fcnt_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
      end
      rise_q <= rise_d;
      fall_q <= fall_d;
      sat_q  <= sat_d;
    end
  end

  always_comb begin
    level        = level_q;
    rising_edge  = rise_q;
    falling_edge = fall_q;
    event_out    = ev;
    any_event    = |ev;
    count_sat    = sat_q;
    event_count  = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      event_count[ch*CNT_W +: CNT_W] = cnt_q[ch];
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: two instances (unfiltered 16-bit counters and
// 4-sample filter with 2-bit counters) checked against a behavioural model.
module tb_multi_edge_detector;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  gate, ch_enable, rise_mask, fall_mask, cnt_clear;

  logic [3:0]  a_level, a_rise, a_fall, a_evt, a_sat;
  logic        a_any;
  logic [63:0] a_cnt;
  logic [3:0]  b_level, b_rise, b_fall, b_evt, b_sat;
  logic        b_any;
  logic [7:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = dut_a, 1 = dut_b
  int         FL[2]   = '{1, 4};
  int         CMAX[2] = '{65535, 3};
  logic [3:0] hist[$];
  bit         m_level[2][4];
  bit         m_rise[2][4];
  bit         m_fall[2][4];
  int         m_run[2][4];
  int         m_cnt[2][4];

  multi_edge_detector #(
    .N_CH(4), .SYNC_STAGES(S), .FILTER_LEN(1), .CNT_W(16), .INIT_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .gate(gate), .ch_enable(ch_enable),
    .rise_mask(rise_mask), .fall_mask(fall_mask), .cnt_clear(cnt_clear),
    .level(a_level), .rising_edge(a_rise), .falling_edge(a_fall),
    .event_out(a_evt), .any_event(a_any), .event_count(a_cnt), .count_sat(a_sat)
  );

  multi_edge_detector #(
    .N_CH(4), .SYNC_STAGES(S), .FILTER_LEN(4), .CNT_W(2), .INIT_LEVEL(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .gate(gate), .ch_enable(ch_enable),
    .rise_mask(rise_mask), .fall_mask(fall_mask), .cnt_clear(cnt_clear),
    .level(b_level), .rising_edge(b_rise), .falling_edge(b_fall),
    .event_out(b_evt), .any_event(b_any), .event_count(b_cnt), .count_sat(b_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] e_level(int d);
    logic [3:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch] = m_level[d][ch];
    return r;
  endfunction

  function automatic logic [3:0] e_rise(int d);
    logic [3:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch] = m_rise[d][ch];
    return r;
  endfunction

  function automatic logic [3:0] e_fall(int d);
    logic [3:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch] = m_fall[d][ch];
    return r;
  endfunction

  function automatic logic [3:0] e_evt(int d);
    return (e_rise(d) & rise_mask) | (e_fall(d) & fall_mask);
  endfunction

  function automatic logic [3:0] e_sat(int d);
    logic [3:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch] = (m_cnt[d][ch] == CMAX[d]);
    return r;
  endfunction

  function automatic logic [63:0] e_cnt_a();
    logic [63:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch*16 +: 16] = m_cnt[0][ch][15:0];
    return r;
  endfunction

  function automatic logic [7:0] e_cnt_b();
    logic [7:0] r;
    for (int ch = 0; ch < 4; ch++) r[ch*2 +: 2] = m_cnt[1][ch][1:0];
    return r;
  endfunction

  // Filter seen as "level follows the synchronised gate once it has disagreed
  // for FL samples in a row"; the synchronised gate is the gate S edges ago.
  task automatic model_update();
    logic [3:0] so;
    bit old, evq;
    if (reset) begin
      hist.delete();
      repeat (S) hist.push_back(4'b0000);
      for (int d = 0; d < 2; d++)
        for (int ch = 0; ch < 4; ch++) begin
          m_level[d][ch] = 1'b0; m_rise[d][ch] = 1'b0; m_fall[d][ch] = 1'b0;
          m_run[d][ch] = 0; m_cnt[d][ch] = 0;
        end
    end else begin
      so = hist.pop_front();
      hist.push_back(gate);
      for (int d = 0; d < 2; d++)
        for (int ch = 0; ch < 4; ch++) begin
          evq = (m_rise[d][ch] && rise_mask[ch]) || (m_fall[d][ch] && fall_mask[ch]);
          if (cnt_clear[ch]) m_cnt[d][ch] = 0;
          else if (evq && m_cnt[d][ch] < CMAX[d]) m_cnt[d][ch]++;
          old = m_level[d][ch];
          if (so[ch] != m_level[d][ch]) begin
            m_run[d][ch]++;
            if (m_run[d][ch] == FL[d]) begin
              m_level[d][ch] = ~m_level[d][ch];
              m_run[d][ch] = 0;
            end
          end else begin
            m_run[d][ch] = 0;
          end
          m_rise[d][ch] = ch_enable[ch] && m_level[d][ch] && !old;
          m_fall[d][ch] = ch_enable[ch] && !m_level[d][ch] && old;
        end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; gate = '0; ch_enable = '1; rise_mask = '1; fall_mask = '1; cnt_clear = '0;
    repeat (10) step();
    checks++;
    if ({a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt} !== '0)
      $display("FAIL reset_hold_a got=%h exp=0", {a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt});
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_rel_a cyc=%0d got=%h exp=0", i, {a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt});
      end
      checks++;
      if ({b_level, b_rise, b_fall, b_evt, b_any, b_sat, b_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_rel_b cyc=%0d got=%h exp=0", i, {b_level, b_rise, b_fall, b_evt, b_any, b_sat, b_cnt});
      end
    end
  endtask

  task automatic test_latency();
    int  n = 0;
    bit  found = 1'b0;
    gate[0] = 1'b1;
    while (!found && n < 20) begin
      step();
      n++;
      if (a_rise[0] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n != 4) begin
      errors++;
      $display("FAIL latency edges got=%0d found=%0d exp=4", n, found);
    end
    checks++;
    if (a_level[0] !== 1'b1 || a_evt[0] !== 1'b1 || a_any !== 1'b1) begin
      errors++;
      $display("FAIL latency_level lvl=%b evt=%b any=%b exp=1,1,1", a_level[0], a_evt[0], a_any);
    end
    step();
    checks++;
    if (a_rise[0] !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width rise=%b exp=0", a_rise[0]);
    end
    checks++;
    if (a_cnt[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL latency_count got=%0d exp=1", a_cnt[15:0]);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    bit lvl_bad = 1'b0;
    gate[1] = 1'b1;
    repeat (3) step();
    gate[1] = 1'b0;
    repeat (12) begin
      step();
      pulses += int'(b_rise[1]);
      if (b_level[1] !== 1'b0) lvl_bad = 1'b1;
    end
    checks++;
    if (pulses != 0 || lvl_bad) begin
      errors++;
      $display("FAIL glitch_short pulses=%0d lvl_bad=%0d exp=0,0", pulses, lvl_bad);
    end
    pulses = 0;
    gate[1] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 4) gate[1] = 1'b0;
      step();
      pulses += int'(b_rise[1]);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL glitch_long pulses=%0d exp=1", pulses);
    end
  endtask

  task automatic test_masks();
    int rs = 0, fs = 0, es = 0;
    bit bad = 1'b0;
    rise_mask[2] = 1'b0;
    gate[2] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 6) gate[2] = 1'b0;
      step();
      rs += int'(a_rise[2]); fs += int'(a_fall[2]); es += int'(a_evt[2]);
      if (a_evt[2] === 1'b1 && a_rise[2] === 1'b1) bad = 1'b1;
    end
    checks++;
    if (rs != 1 || fs != 1 || es != 1 || bad) begin
      errors++;
      $display("FAIL mask_pulses rise=%0d fall=%0d evt=%0d evt_on_rise=%0d exp=1,1,1,0", rs, fs, es, bad);
    end
    checks++;
    if (a_cnt[47:32] !== 16'd1) begin
      errors++;
      $display("FAIL mask_count got=%0d exp=1", a_cnt[47:32]);
    end
    rise_mask[2] = 1'b1;
  endtask

  task automatic test_saturation();
    fall_mask[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gate[3] = 1'b1;
      repeat (8) step();
      checks++;
      if (b_cnt[7:6] !== 2'((i + 1 > 3) ? 3 : i + 1) || b_sat[3] !== (i >= 2)) begin
        errors++;
        $display("FAIL sat_count ev=%0d got=%0d sat=%b exp=%0d sat=%0d", i + 1, b_cnt[7:6], b_sat[3], (i + 1 > 3) ? 3 : i + 1, i >= 2);
      end
      gate[3] = 1'b0;
      repeat (8) step();
    end
    gate[3] = 1'b1;
    repeat (7) step();
    checks++;
    if (b_rise[3] !== 1'b1 || b_evt[3] !== 1'b1) begin
      errors++;
      $display("FAIL clear_pulse rise=%b evt=%b exp=1,1", b_rise[3], b_evt[3]);
    end
    cnt_clear[3] = 1'b1;
    step();
    cnt_clear[3] = 1'b0;
    checks++;
    if (b_cnt[7:6] !== 2'd0 || b_sat[3] !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority got=%0d sat=%b exp=0 sat=0", b_cnt[7:6], b_sat[3]);
    end
    fall_mask[3] = 1'b1;
  endtask

  task automatic test_enable_and_reset();
    int pulses = 0;
    gate[0] = 1'b0;
    repeat (8) step();
    ch_enable[0] = 1'b0;
    gate[0] = 1'b1;
    repeat (8) begin
      step();
      pulses += int'(a_rise[0]) + int'(a_fall[0]);
    end
    ch_enable[0] = 1'b1;
    repeat (8) begin
      step();
      pulses += int'(a_rise[0]) + int'(a_fall[0]);
    end
    checks++;
    if (pulses != 0 || a_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_gap pulses=%0d lvl=%b exp=0,1", pulses, a_level[0]);
    end
    gate = ~gate;
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if ({a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_a got=%h exp=0", {a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt});
    end
    checks++;
    if ({b_level, b_rise, b_fall, b_evt, b_any, b_sat, b_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_b got=%h exp=0", {b_level, b_rise, b_fall, b_evt, b_any, b_sat, b_cnt});
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(7) == 0) gate[ch] = ~gate[ch];
      if ($urandom_range(49) == 0) rise_mask = 4'($urandom);
      if ($urandom_range(49) == 0) fall_mask = 4'($urandom);
      if ($urandom_range(59) == 0) ch_enable = 4'($urandom);
      cnt_clear = ($urandom_range(39) == 0) ? 4'($urandom) : 4'b0000;
      reset = ($urandom_range(599) == 0);
      step();
      checks++;
      if ({a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt} !==
          {e_level(0), e_rise(0), e_fall(0), e_evt(0), |e_evt(0), e_sat(0), e_cnt_a()}) begin
        errors++;
        $display("FAIL rand_a cyc=%0d got=%h exp=%h", i,
                 {a_level, a_rise, a_fall, a_evt, a_any, a_sat, a_cnt},
                 {e_level(0), e_rise(0), e_fall(0), e_evt(0), |e_evt(0), e_sat(0), e_cnt_a()});
      end
      checks++;
      if ({b_level, b_rise, b_fall, b_evt, b_any, b_sat, b_cnt} !==
          {e_level(1), e_rise(1), e_fall(1), e_evt(1), |e_evt(1), e_sat(1), e_cnt_b()}) begin
        errors++;
        $display("FAIL rand_b cyc=%0d got=%h exp=%h", i,
                 {b_level, b_rise, b_fall, b_evt, b_any, b_sat, b_cnt},
                 {e_level(1), e_rise(1), e_fall(1), e_evt(1), |e_evt(1), e_sat(1), e_cnt_b()});
      end
    end
    reset = 1'b0;
    cnt_clear = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_masks();
    test_saturation();
    test_enable_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
